// File: rtl/ro_freq_meter_if.sv
// Measurement-side signal bundle for ro_freq_meter.
// The ovf signal exists only when RO_MEAS_OVF_EN is defined.
interface ro_freq_meter_if #(
  parameter int CW = 16
);
  logic          ring_tap;
  logic          start;
  logic          shift;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          sdo;
`ifdef RO_MEAS_OVF_EN
  logic          ovf;
`endif

  modport master (
    output ring_tap, start, shift,
    input  busy, done, count, sdo
`ifdef RO_MEAS_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  ring_tap, start, shift,
    output busy, done, count, sdo
`ifdef RO_MEAS_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized ring_tap rises over a
// 2^GATE_LOG2-cycle gate, latches the result and shifts it out MSB first.
// Optional macro RO_MEAS_OVF_EN adds the ovf flag (prepended to the serial word).
module ro_freq_meter #(
  parameter int CW        = 16,
  parameter int GATE_LOG2 = 12
) (
  input logic           clk,
  input logic           reset,
  ro_freq_meter_if.slave mif
);

`ifdef RO_MEAS_OVF_EN
  localparam int SRW = CW + 1;
`else
  localparam int SRW = CW;
`endif

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_t;

  state_t               r_state;
  logic                 r_tap_s1, r_tap_s2, r_tap_s3, r_tap_rise;
  logic                 r_sh_s1, r_sh_s2, r_sh_s3, r_sh_rise;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_count;
  logic [GATE_LOG2-1:0] r_timer;
  logic [SRW-1:0]       r_sr;
  logic                 r_busy;
  logic                 r_done;
`ifdef RO_MEAS_OVF_EN
  logic                 r_sat;
  logic                 r_ovf;
  logic                 w_sat_next;
`endif

  logic                 w_at_max;
  logic [CW-1:0]        w_cnt_next;
  logic                 w_begin;

  // Both asynchronous inputs get a 2-flop synchronizer, a delay flop and a
  // registered rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tap_s1   <= 1'b0;
      r_tap_s2   <= 1'b0;
      r_tap_s3   <= 1'b0;
      r_tap_rise <= 1'b0;
      r_sh_s1    <= 1'b0;
      r_sh_s2    <= 1'b0;
      r_sh_s3    <= 1'b0;
      r_sh_rise  <= 1'b0;
    end else begin
      r_tap_s1   <= mif.ring_tap;
      r_tap_s2   <= r_tap_s1;
      r_tap_s3   <= r_tap_s2;
      r_tap_rise <= r_tap_s2 & ~r_tap_s3;
      r_sh_s1    <= mif.shift;
      r_sh_s2    <= r_sh_s1;
      r_sh_s3    <= r_sh_s2;
      r_sh_rise  <= r_sh_s2 & ~r_sh_s3;
    end
  end

  // Saturating increment; the final-cycle rise is folded into the captured value.
  assign w_at_max   = &r_cnt;
  assign w_cnt_next = (r_tap_rise && !w_at_max) ? r_cnt + 1'b1 : r_cnt;
`ifdef RO_MEAS_OVF_EN
  assign w_sat_next = r_sat | (r_tap_rise & w_at_max);
`endif

  // start is honoured in IDLE and DONE only, and beats a coincident shift.
  assign w_begin = mif.start && (r_state != S_GATE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_count <= '0;
      r_timer <= '0;
      r_sr    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef RO_MEAS_OVF_EN
      r_sat   <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else if (w_begin) begin
      r_state <= S_GATE;
      r_cnt   <= '0;
      r_timer <= '1;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
`ifdef RO_MEAS_OVF_EN
      r_sat   <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_GATE: begin
          r_cnt   <= w_cnt_next;
          r_timer <= r_timer - 1'b1;
`ifdef RO_MEAS_OVF_EN
          r_sat   <= w_sat_next;
`endif
          if (r_timer == '0) begin
            r_count <= w_cnt_next;
`ifdef RO_MEAS_OVF_EN
            r_sr    <= {w_sat_next, w_cnt_next};
            r_ovf   <= w_sat_next;
`else
            r_sr    <= w_cnt_next;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_sh_rise) r_sr <= {r_sr[SRW-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign mif.busy  = r_busy;
  assign mif.done  = r_done;
  assign mif.count = r_count;
  assign mif.sdo   = r_sr[SRW-1];
`ifdef RO_MEAS_OVF_EN
  assign mif.ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboard bench for ro_freq_meter: CW=16 and CW=4 instances share stimulus;
// expected results come from a rise-counting model over the gate window.
module tb_ro_freq_meter;
  localparam int GL = 8;
  localparam int N  = 1 << GL;
`ifdef RO_MEAS_OVF_EN
  localparam int OV = 1;
`else
  localparam int OV = 0;
`endif
  localparam int SRW16 = 16 + OV;
  localparam int SRW4  = 4 + OV;

  typedef struct {
    int          n16;
    int          n4;
    bit          ov16;
    bit          ov4;
    logic [16:0] v16;
    logic [16:0] v4;
  } exp_t;

  typedef struct {
    bit b16;
    bit b4;
    bit cc;
    int c16;
  } sdo_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ring_tap, start, shift, chk;
  always #5 clk = ~clk;

  ro_freq_meter_if #(.CW(16)) if16();
  ro_freq_meter_if #(.CW(4))  if4();
  assign if16.ring_tap = ring_tap;
  assign if16.start    = start;
  assign if16.shift    = shift;
  assign if4.ring_tap  = ring_tap;
  assign if4.start     = start;
  assign if4.shift     = shift;

  ro_freq_meter #(.CW(16), .GATE_LOG2(GL)) u16 (.clk(clk), .reset(reset), .mif(if16.slave));
  ro_freq_meter #(.CW(4),  .GATE_LOG2(GL)) u4  (.clk(clk), .reset(reset), .mif(if4.slave));

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tp_per = 8, tp_ph = 0;
  bit   tp_en = 0, tp_const = 0;
  exp_t q_exp[$];
  sdo_t q_sdo[$];
  exp_t pv;
  int   psh = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Tap waveform value driven just after clk edge c: high for the first half
  // of each period, rising when c == tp_ph (mod tp_per).
  function automatic bit tapv(input int c);
    int m;
    if (!tp_en) return tp_const;
    m = (c - tp_ph) % tp_per;
    if (m < 0) m += tp_per;
    return m < tp_per / 2;
  endfunction

  // A rise driven after edge c is counted at edge c+4; the gate counts edges T+1..T+N.
  function automatic int model_n(input int T);
    int n = 0;
    for (int c = T - 3; c <= T + N - 4; c++)
      if (tapv(c) && !tapv(c - 1)) n++;
    return n;
  endfunction

  function automatic bit seqbit(input logic [16:0] v, input int w, input int i);
    if (i >= w) return 1'b0;
    return v[w-1-i];
  endfunction

  function automatic exp_t mk_exp(input int n);
    exp_t e;
    e.n16  = (n > 65535) ? 65535 : n;
    e.ov16 = n > 65535;
    e.n4   = (n > 15) ? 15 : n;
    e.ov4  = n > 15;
    e.v16  = {e.ov16, 16'(e.n16)};
    e.v4   = 17'({e.ov4, 4'(e.n4)});
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Ring tap driver: one update per clk edge.
  initial begin
    ring_tap = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ring_tap = tapv(cyc);
    end
  end

  // Monitor: pops the scoreboard on each done rise and on each sdo probe.
  initial begin
    exp_t e;
    sdo_t s;
    int   bcnt = 0;
    bit   pdone = 0, pbusy = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bcnt = 0;
        pdone = 0;
        pbusy = 0;
      end else begin
        if (if16.busy) bcnt = pbusy ? bcnt + 1 : 1;
        if (if16.done && !pdone) begin
          if (q_exp.size() == 0) check("unexpected_done", 1, 0);
          else begin
            e = q_exp.pop_front();
            check("count16", int'(if16.count), e.n16);
            check("count4", int'(if4.count), e.n4);
            check("done4", int'(if4.done), 1);
            check("gate_len", bcnt, N);
            check("sdo16_first", int'(if16.sdo), int'(seqbit(e.v16, SRW16, 0)));
            check("sdo4_first", int'(if4.sdo), int'(seqbit(e.v4, SRW4, 0)));
`ifdef RO_MEAS_OVF_EN
            check("ovf16", int'(if16.ovf), int'(e.ov16));
            check("ovf4", int'(if4.ovf), int'(e.ov4));
`endif
          end
        end
        if (chk) begin
          if (q_sdo.size() == 0) check("unexpected_probe", 1, 0);
          else begin
            s = q_sdo.pop_front();
            check("sdo16", int'(if16.sdo), int'(s.b16));
            check("sdo4", int'(if4.sdo), int'(s.b4));
            if (s.cc) check("count16_hold", int'(if16.count), s.c16);
          end
        end
        pdone = if16.done;
        pbusy = if16.busy;
      end
    end
  end

  task automatic probe(input bit b16, input bit b4, input bit cc, input int c16);
    sdo_t s;
    s.b16 = b16; s.b4 = b4; s.cc = cc; s.c16 = c16;
    q_sdo.push_back(s);
    chk = 1'b1;
    tick;
    chk = 1'b0;
  endtask

  task automatic shift_out(input int nsh);
    for (int i = 0; i < nsh; i++) begin
      shift = 1'b1;
      repeat (4) tick;
      shift = 1'b0;
      repeat (4) tick;
      psh++;
      probe(seqbit(pv.v16, SRW16, psh), seqbit(pv.v4, SRW4, psh), 1'b1, pv.n16);
    end
  endtask

  // mode: 0 plain, 1 extra start mid-gate, 2 start coincides with a shift
  // edge, 3 reset 100 cycles into the gate. force_n >= 0 overrides the model.
  task automatic measure(input int per, input int ph_rel, input bit en, input bit cst,
                         input int force_n, input int mode);
    int   T, k;
    exp_t e;
    tick;
    T = cyc + 10;
    tp_en = en; tp_const = cst; tp_per = per; tp_ph = T + ph_rel;
    while (cyc < T - 1) begin
      tick;
      if (mode == 2 && cyc == T - 4) shift = 1'b1;
    end
    e = mk_exp(force_n >= 0 ? force_n : model_n(T));
    if (mode != 3) q_exp.push_back(e);
    start = 1'b1;
    tick;
    start = 1'b0;
    if (mode == 2) begin
      repeat (3) tick;
      shift = 1'b0;
      repeat (16) tick;
      probe(seqbit(pv.v16, SRW16, psh), seqbit(pv.v4, SRW4, psh), 1'b0, 0);
    end
    if (mode == 1) begin
      repeat (50) tick;
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    if (mode == 3) begin
      repeat (99) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("rst_mid_busy", int'(if16.busy), 0);
      check("rst_mid_done", int'(if16.done), 0);
      check("rst_mid_count", int'(if16.count), 0);
      check("rst_mid_sdo", int'(if16.sdo), 0);
      pv = mk_exp(0);
      psh = 0;
      repeat (N + 10) tick;
      check("rst_mid_no_done", int'(if16.done), 0);
      return;
    end
    k = 0;
    while (!if16.done && k < N + 40) begin
      tick;
      k++;
    end
    if (!if16.done) check("done_timeout", 0, 1);
    repeat (2) tick;
    pv = e;
    psh = 0;
  endtask

  initial begin
    start = 0; shift = 0; chk = 0;
    pv = mk_exp(0);
    tp_en = 1; tp_per = 4;
    repeat (3) tick;
    check("rst_busy", int'(if16.busy), 0);
    check("rst_done", int'(if16.done), 0);
    check("rst_count", int'(if16.count), 0);
    check("rst_sdo", int'(if16.sdo), 0);
    check("rst_count4", int'(if4.count), 0);
    reset = 0;
    repeat (20) tick;
    check("idle_busy", int'(if16.busy), 0);
    check("idle_done", int'(if16.done), 0);

    measure(8, 0, 1'b0, 1'b0, 0, 0);
    shift_out(3);
    measure(8, 4, 1'b1, 1'b0, 32, 0);
    shift_out(SRW16 + 1);
    measure(10, 6, 1'b1, 1'b0, 25, 0);
    measure(7, 0, 1'b1, 1'b0, -1, 0);
    shift_out(SRW16 + 2);
    measure(4, 0, 1'b1, 1'b0, 64, 0);
    shift_out(SRW4 + 1);
    measure(20, 3, 1'b1, 1'b0, -1, 1);
    measure(24, 0, 1'b1, 1'b0, -1, 0);
    measure(9, 2, 1'b1, 1'b0, -1, 2);
    measure(6, 1, 1'b1, 1'b0, -1, 3);
    for (int r = 0; r < 5; r++) begin
      measure(int'($urandom_range(4, 40)), int'($urandom_range(0, 39)), 1'b1, 1'b0, -1, 0);
      shift_out(int'($urandom_range(0, SRW16 + 1)));
    end

    repeat (5) tick;
    check("exp_left", q_exp.size(), 0);
    check("sdo_left", q_sdo.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "simulation time limit exceeded");
  end
endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
Measurement stage directly downstream of the ring-oscillator worker. It consumes the worker's divided ring output (the clock_div[3] tap) and counts its rising edges over a fixed window of clk cycles. The result is latched and exposed in parallel. It is also shifted out serially, MSB first, on the shared shift pin, with a done flag for the off-chip host. The whole block runs on the single system clock; the ring tap is treated as fully asynchronous.

Parameters:
CW, 16, width of edge counter and result register (bits)
GATE_LOG2, 12, gate window length = 2^GATE_LOG2 clk cycles (range 2..20)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ring_tap  input  1  asynchronous divided ring-oscillator output
start  input  1  synchronous level; sampled high in IDLE/DONE begins a measurement
shift  input  1  asynchronous shift strobe from pad; each rising edge advances serial output one bit
busy  output  1  high while gate window is open
done  output  1  high while a valid result is held
count  output  CW  latched result; stable while done=1
sdo  output  1  serial data out = MSB of shift register
ovf  output  1  result saturated (present only with RO_MEAS_OVF_EN)

Behaviour:
- Reset (sync, clk edge with reset=1): state=IDLE; busy=0, done=0, count=0, sdo=0, ovf=0. Synchronizers and timer cleared. Reset overrides everything, including mid-gate: the partial count is discarded.
- ring_tap path: 2-flop synchronizer, then a delay flop. tap_rise = sync2 & ~sync3, registered. A ring_tap rise is seen as tap_rise 3 clk edges later.
- shift path: identical 2-flop sync + edge detect producing a 1-cycle shift_rise.
- FSM states: IDLE, GATE, DONE.
- IDLE -> GATE when start=1 at edge T. At T: edge counter := 0, timer := 2^GATE_LOG2-1, busy := 1, done := 0.
- GATE: lasts exactly 2^GATE_LOG2 cycles, T+1..T+2^GATE_LOG2.
  - Each cycle with tap_rise=1 increments the counter; the last-cycle tap_rise is counted.
  - Counter saturates at 2^CW-1 and never wraps; the saturation flag is set when an increment is attempted at max.
  - Timer decrements each cycle.
  - On the cycle timer==0: count := counter (plus last-cycle increment), shift register := same value, busy := 0, done := 1 (visible from T+2^GATE_LOG2+1), state := DONE.
  - start is ignored in GATE; shift_rise is ignored in GATE.
- DONE:
  - shift_rise: shift register shifts left one bit, LSB filled with 0. sdo always equals shift register MSB, so the first bit is valid before any shift.
  - After CW shifts, sdo=0 and stays 0.
  - count is unaffected by shifting.
  - start=1 -> new measurement exactly as from IDLE (done := 0). start and shift_rise in the same cycle: start wins, shift discarded.
- ring_tap held constant: count=0. Edges faster than clk/4 alias; accuracy is only specified for tap period >= 4 clk cycles.

Optional Feature:
RO_MEAS_OVF_EN
- Defined:
  - ovf port exists; ovf := saturation flag at capture; cleared on start and on reset.
  - The shift register is CW+1 bits with ovf as MSB, so sdo emits ovf first, then count MSB..LSB.
  - CW+1 shifts drain it.
- Undefined:
  - No ovf port; saturation is silent.
  - The shift register is CW bits.

Test Plan:
1. Reset: hold reset 3 cycles with ring_tap toggling -> busy=0, done=0, count=0, sdo=0. Deassert; no activity without start.
2. ring_tap=0 constant, GATE_LOG2=8, start pulse at T -> busy=1 on T+1..T+256, done=1 at T+257, count=0.
3. GATE_LOG2=8, ring_tap driven from clk with period 8, rises at cycles 4 mod 8 relative to T; start at T -> count=32 exactly. Repeat with period 10, rises at 6 mod 10 -> count=25 (26 rises fall in the window; the last is still in the synchronizer when the gate closes).
4. Shift-out, CW=16, macro off: result 0x0025 -> sdo before any shift = 0. 16 shift rising edges (each held 4 clk) -> sdo sequence 0,0,0,0,0,0,0,0,0,0,1,0,0,1,0,1, then 0. count stays 0x0025.
5. Saturation, CW=4, GATE_LOG2=8, tap period 4 -> count=15. With RO_MEAS_OVF_EN: ovf=1, first sdo bit 1, then 1,1,1,1.
6. Robustness:
   - start pulsed mid-GATE is ignored.
   - reset at cycle T+100 -> IDLE, done=0, count=0.
   - In DONE, start and shift edge coincide -> new measurement begins and the shift register is not shifted.
